// File: rtl/ariane_pkg.sv
// Minimal stand-in for the Ariane frontend types used by the fetch entry buffer.
// Field layout mirrors the core's fetch_entry_t closely enough for decode hand-off.
package ariane_pkg;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [2:0]  cf;
    logic [63:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [63:0]        address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
    exception_t         ex;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_buffer_if.sv
// Handshake bundle between frontend, fetch entry buffer and decode.
// The master side is the environment (frontend + decode), the slave side is the buffer.
interface fetch_entry_buffer_if #(
  parameter int unsigned Depth = 4
);

  logic                     flush_i;
  ariane_pkg::fetch_entry_t fetch_entry_i;
  logic                     fetch_entry_valid_i;
  logic                     fetch_entry_ready_o;
  ariane_pkg::fetch_entry_t fetch_entry_o;
  logic                     fetch_entry_valid_o;
  logic                     fetch_entry_ready_i;
  logic [$clog2(Depth):0]   usage_o;

  modport master (
    output flush_i,
    output fetch_entry_i,
    output fetch_entry_valid_i,
    input  fetch_entry_ready_o,
    input  fetch_entry_o,
    input  fetch_entry_valid_o,
    output fetch_entry_ready_i,
    input  usage_o
  );

  modport slave (
    input  flush_i,
    input  fetch_entry_i,
    input  fetch_entry_valid_i,
    output fetch_entry_ready_o,
    output fetch_entry_o,
    output fetch_entry_valid_o,
    input  fetch_entry_ready_i,
    output usage_o
  );

endinterface

// File: rtl/fetch_entry_buffer.sv
// In-order FIFO decoupling the frontend from decode; single-cycle flush and
// a frontend ready that depends only on the stored count.
module fetch_entry_buffer #(
  parameter int unsigned Depth = 4
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  fetch_entry_buffer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  ariane_pkg::fetch_entry_t mem [Depth];

  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  assign bus.fetch_entry_ready_o = (count_q != CntW'(Depth));
  assign bus.fetch_entry_valid_o = (count_q != '0);
  assign bus.fetch_entry_o       = mem[rptr_q];
  assign bus.usage_o             = count_q;

  assign push = bus.fetch_entry_valid_i && bus.fetch_entry_ready_o && !bus.flush_i;
  assign pop  = bus.fetch_entry_valid_o && bus.fetch_entry_ready_i && !bus.flush_i;

  // Flush wins over everything; otherwise pointers advance independently
  // and the count only moves when exactly one side transfers.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (bus.flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; the head is only meaningful while valid is high.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= bus.fetch_entry_i;
  end

endmodule

// File: doc/fetch_entry_buffer.md
# fetch_entry_buffer

Decoupling FIFO between the frontend instruction queue and the decode stage. It accepts `ariane_pkg::fetch_entry_t` entries from the frontend, stores up to `Depth` of them in order, and presents the oldest entry to decode through a valid/ready handshake. On a pipeline flush it discards all stored entries in a single cycle. It registers the frontend-facing ready, so that path carries no combinational dependence on decode back-pressure.

## Interface
- `Depth`, default 4: number of entries; power of two, ≥ 2.
- `clk_i` input 1: clock, rising edge.
- `rst_ni` input 1: asynchronous active-low reset.
- `flush_i` input 1: discard all stored entries and any push in the same cycle.
- `fetch_entry_i` input `$bits(ariane_pkg::fetch_entry_t)`: entry from the frontend.
- `fetch_entry_valid_i` input 1: frontend entry valid.
- `fetch_entry_ready_o` output 1: buffer can accept an entry (= not full).
- `fetch_entry_o` output `$bits(ariane_pkg::fetch_entry_t)`: oldest stored entry (head).
- `fetch_entry_valid_o` output 1: head is valid (= not empty).
- `fetch_entry_ready_i` input 1: decode accepts the head this cycle.
- `usage_o` output `$clog2(Depth)+1`: number of stored entries, 0..`Depth`.

## Operation
- **Storage:** `Depth`-entry register array, plus read pointer and write pointer, each `$clog2(Depth)` bits, each wrapping modulo `Depth`. A separate count register, `$clog2(Depth)+1` bits, distinguishes full from empty.
- **Push:** `push = fetch_entry_valid_i && fetch_entry_ready_o && !flush_i`. On a push, write `mem[wptr] <= fetch_entry_i` and set `wptr <= wptr+1`.
- **Pop:** `pop = fetch_entry_valid_o && fetch_entry_ready_i && !flush_i`. On a pop, set `rptr <= rptr+1`.
- **Count update:** +1 on push only, −1 on pop only, unchanged when both or neither occur.
- **Output mapping:** `fetch_entry_o = mem[rptr]` (combinational read). `fetch_entry_valid_o = (count != 0)`. `fetch_entry_ready_o = (count != Depth)`. `usage_o = count`.
- **Flush:** `flush_i` has priority over push and pop. Next cycle, `rptr`, `wptr` and `count` are all 0. Memory contents are not cleared. Outputs during the flush cycle itself are not altered, because decode ignores them under flush.
- **Ordering:** entries leave in exactly the order they were accepted. No entry is duplicated or dropped, except on flush.
- **Illegal handshakes:** pop with `count==0` has no effect. `fetch_entry_valid_i` without ready has no effect, and the frontend holds its entry.
- **Exceptions:** the `ex` and `branch_predict` fields pass through unmodified as part of the entry.

## Timing
- **Reset:** `rptr`, `wptr` and `count` are 0. This gives `fetch_entry_valid_o`=0, `fetch_entry_ready_o`=1 and `usage_o`=0. `fetch_entry_o` is don't-care while valid is low.
- **Latency:** an entry pushed in cycle N is visible at `fetch_entry_o` with valid=1 in cycle N+1. There is no bypass from input to output.
- **Ready is registered-state only:** `fetch_entry_ready_o` depends only on `count`. When full, a simultaneous pop does not enable a push in the same cycle; ready rises in the following cycle.
- **Full with pop:** when `count==Depth` and pop is asserted, `count` becomes `Depth-1` and ready is 1 next cycle.
- **Empty with push:** when `count==0` and push is asserted, valid is 1 next cycle. No pop can occur in the push cycle.
- **Push and pop together:** when `0<count<Depth` and both push and pop occur, `count` is unchanged and both pointers advance.
- **Pointer wrap-around:** the transition from `Depth-1` to 0 is seamless, with no bubble.
- **Flush in the middle of a fill:** the entry offered in the flush cycle is discarded. The first entry the buffer can accept after a flush is offered in cycle N+1.
- **Reset mid-operation:** asynchronous assertion immediately forces the reset values above. Deassertion is synchronous to `clk_i` by convention.
- **Throughput:** one entry per cycle sustained, as long as `count<Depth` or decode drains.

## Test plan
- **Reset / idle:** hold `rst_ni`=0, then release with no traffic. Required: valid_o=0, ready_o=1 and usage_o=0 on every cycle.
- **Single-entry latency (`Depth`=4):** push entry A with address 0x80000000 in cycle 1, `fetch_entry_ready_i`=0. Required: cycle 2 shows valid_o=1, `fetch_entry_o.address`=0x80000000 and usage_o=1. Pop in cycle 3; cycle 4 shows valid_o=0.
- **Fill to full, then pop and push together:**
  - Push 4 entries A–D with no pops. Required: after 4 cycles usage_o=4 and ready_o=0.
  - In the next cycle, assert pop together with frontend entry E valid. Required: E is not accepted and usage_o=3. Ready_o=1 in the following cycle, and E is accepted there.
  - Drain. Required order: B, C, D, E.
- **Wrap-around streaming:** continuous push of 12 entries with addresses 0x0, 0x4, … and continuous pop. Required: usage_o settles at 1, and output addresses are in order 0x0 … 0x2C with no gaps, duplicates or bubbles.
- **Flush with concurrent push:** with 3 entries stored, assert `flush_i` together with frontend entry X valid and decode ready. Required: next cycle valid_o=0 and usage_o=0. X never appears at the output. A push of Y in the next cycle appears as the head one cycle later.
- **Asynchronous reset mid-stream:** with 2 entries stored, pull `rst_ni` low between clock edges. Required: valid_o=0 and usage_o=0 immediately, before the next edge. After release, the buffer accepts new entries normally.
